rv64_seq_divider: RTL and testbench



---
 rtl/rv64_div_pkg.sv | 27 ++
 rtl/rv64_div_step.sv | 53 +++++
 rtl/rv64_seq_divider.sv | 144 ++++++++++++++
 tb/tb_rv64_seq_divider.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/rv64_div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : rv64_div_pkg                                                |
// | Desc   : Shared widths, op/state encodings for the RV64M divider     |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package rv64_div_pkg;

  localparam int XLEN  = 64;
  localparam int CNT_W = 7;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  localparam int         OP_W_BIT = 2;

  localparam logic [XLEN-1:0] MIN_SIGNED = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/rv64_div_step.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : rv64_div_step                                               |
// | Desc   : One restoring-division iteration; 65-bit trial subtract     |
// |          built as a 4-bit-group carry-lookahead add of ~divisor + 1  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
import rv64_div_pkg::*;

module rv64_div_step (
  input  logic [XLEN-1:0] rem_i,
  input  logic            dvd_msb_i,
  input  logic [XLEN-1:0] dvs_i,
  output logic [XLEN-1:0] rem_o,
  output logic            q_o
);

  logic [XLEN-1:0]   rem_sh;
  logic [XLEN-1:0]   inv_dvs;
  logic [XLEN-1:0]   g;
  logic [XLEN-1:0]   p;
  logic [XLEN-1:0]   diff;
  logic [XLEN/4:0]   c;
  logic              trial_neg;

  assign rem_sh  = {rem_i[XLEN-2:0], dvd_msb_i};
  assign inv_dvs = ~dvs_i;
  assign g       = rem_sh & inv_dvs;
  assign p       = rem_sh ^ inv_dvs;
  assign c[0]    = 1'b1;

  for (genvar k = 0; k < XLEN/4; k++) begin : g_cla
    localparam int B = 4*k;
    logic c1, c2, c3, gg, pg;
    assign c1 = g[B]   | (p[B]   & c[k]);
    assign c2 = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & c[k]);
    assign c3 = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
              | (p[B+2] & p[B+1] & p[B] & c[k]);
    assign gg = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
              | (p[B+3] & p[B+2] & p[B+1] & g[B]);
    assign pg = &p[B+3:B];
    assign c[k+1]    = gg | (pg & c[k]);
    assign diff[B+3:B] = p[B+3:B] ^ {c3, c2, c1, c[k]};
  end

  // Bit 64 of the 65-bit sum: operand bits are 0 and 1 (inverted zero-extension).
  assign trial_neg = 1'b1 ^ c[XLEN/4];

  assign q_o   = ~trial_neg;
  assign rem_o = trial_neg ? rem_sh : diff;

endmodule
`default_nettype wire

// File: rtl/rv64_seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : rv64_seq_divider                                            |
// | Desc   : Sequential restoring divider for DIV/DIVU/REM/REMU; define  |
// |          RV64_DIVW_EN to add the 32-bit W variants (op[2]=1)         |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
import rv64_div_pkg::*;

module rv64_seq_divider (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_e           state_q;
  logic [CNT_W-1:0] count_q;
  logic [XLEN-1:0]  dvd_q, dvs_q, rem_q, quot_q, result_q;
  logic             busy_q, done_q, neg_q_q, neg_r_q, is_rem_q, w_q;

  logic             is_signed, is_rem, is_w;
  logic [XLEN-1:0]  a_val, b_val, a_mag, b_mag, dvd_init, min_val;
  logic             sign_a, sign_b, div_zero, overflow;
  logic [XLEN-1:0]  step_rem, q_fix, r_fix, sel, result_d;
  logic             step_q;
  logic [CNT_W-1:0] last_cnt;

  assign is_signed = ~op[0];
  assign is_rem    = op[1];

`ifdef RV64_DIVW_EN
  assign is_w     = op[OP_W_BIT];
  assign a_val    = is_w ? {{32{is_signed & rs1[31]}}, rs1[31:0]} : rs1;
  assign b_val    = is_w ? {{32{is_signed & rs2[31]}}, rs2[31:0]} : rs2;
  assign min_val  = is_w ? 64'hFFFF_FFFF_8000_0000 : MIN_SIGNED;
  // Pre-shifting the W dividend lets 32 iterations consume only its low word.
  assign dvd_init = is_w ? {a_mag[31:0], 32'h0} : a_mag;
`else
  logic unused_op_w;
  assign unused_op_w = op[OP_W_BIT];
  assign is_w     = 1'b0;
  assign a_val    = rs1;
  assign b_val    = rs2;
  assign min_val  = MIN_SIGNED;
  assign dvd_init = a_mag;
`endif

  assign sign_a   = is_signed & a_val[XLEN-1];
  assign sign_b   = is_signed & b_val[XLEN-1];
  assign a_mag    = sign_a ? -a_val : a_val;
  assign b_mag    = sign_b ? -b_val : b_val;
  assign div_zero = (b_val == '0);
  assign overflow = is_signed & (a_val == min_val) & (b_val == '1);
  assign last_cnt = w_q ? CNT_W'(31) : CNT_W'(XLEN-1);

  rv64_div_step u_step (
    .rem_i     (rem_q),
    .dvd_msb_i (dvd_q[XLEN-1]),
    .dvs_i     (dvs_q),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  assign q_fix = neg_q_q ? -quot_q : quot_q;
  assign r_fix = neg_r_q ? -rem_q  : rem_q;
  assign sel   = is_rem_q ? r_fix : q_fix;
`ifdef RV64_DIVW_EN
  assign result_d = w_q ? {{32{sel[31]}}, sel[31:0]} : sel;
`else
  assign result_d = sel;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      is_rem_q <= 1'b0;
      w_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q   <= 1'b1;
            count_q  <= '0;
            is_rem_q <= is_rem;
            w_q      <= is_w;
            if (div_zero || overflow) begin
              // Preloaded answers are final; FIX must not re-sign them.
              quot_q  <= div_zero ? '1 : a_val;
              rem_q   <= div_zero ? a_val : '0;
              neg_q_q <= 1'b0;
              neg_r_q <= 1'b0;
              state_q <= ST_FIX;
            end else begin
              dvd_q   <= dvd_init;
              dvs_q   <= b_mag;
              rem_q   <= '0;
              quot_q  <= '0;
              neg_q_q <= sign_a ^ sign_b;
              neg_r_q <= sign_a;
              state_q <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          rem_q   <= step_rem;
          quot_q  <= {quot_q[XLEN-2:0], step_q};
          dvd_q   <= {dvd_q[XLEN-2:0], 1'b0};
          count_q <= count_q + 1'b1;
          if (count_q == last_cnt) state_q <= ST_FIX;
        end
        ST_FIX: begin
          result_q <= result_d;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_rv64_seq_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_rv64_seq_divider                                         |
// | Desc   : Directed self-checking bench for rv64_seq_divider           |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tb_rv64_seq_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [63:0] rs1 = '0;
  logic [63:0] rs2 = '0;
  logic        busy, done;
  logic [63:0] result;

  int n_checks = 0;
  int n_errors = 0;

  rv64_seq_divider dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs1    (rs1),
    .rs2    (rs2),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one operation; poke>0 pulses a competing start at that cycle of the run.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input int exp_lat,
                        input int poke);
    int   lat;
    int   busy_cyc;
    logic seen;
    @(posedge clk); #1;
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0; seen = 1'b0;
    busy_cyc = busy ? 1 : 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (lat == poke) begin
        start = 1'b1; op = 3'b000; rs1 = 64'd7; rs2 = 64'd7;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1'b1;
      else if (busy) busy_cyc++;
    end
    start = 1'b0;
    check_eq({tag, " done_seen"}, 64'(seen), 64'd1);
    check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, " busy_cycles"}, 64'(busy_cyc), 64'(exp_lat));
    check_eq({tag, " busy_at_done"}, 64'(busy), 64'd0);
    check_eq({tag, " result"}, result, exp);
    @(posedge clk); #1;
    check_eq({tag, " done_pulse"}, 64'(done), 64'd0);
    check_eq({tag, " result_hold"}, result, exp);
  endtask

  initial begin
    int saw_done;
    #12;
    check_eq("reset busy", 64'(busy), 64'd0);
    check_eq("reset done", 64'(done), 64'd0);
    check_eq("reset result", result, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_op("divu_100_7",  3'b001, 64'd100, 64'd7, 64'd14, 65, -1);
    run_op("remu_100_7",  3'b011, 64'd100, 64'd7, 64'd2,  65, -1);
    run_op("div_m7_2",    3'b000, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 65, -1);
    run_op("rem_m7_2",    3'b010, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65, -1);
    run_op("div_7_m2",    3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 65, -1);
    run_op("rem_7_m2",    3'b010, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 65, -1);
    run_op("divu_max_3",  3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 65, -1);
    run_op("divu_5_0",    3'b001, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, -1);
    run_op("remu_5_0",    3'b011, 64'd5, 64'd0, 64'd5, 1, -1);
    run_op("rem_m5_0",    3'b010, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 1, -1);
    run_op("div_ovf",     3'b000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1, -1);
    run_op("rem_ovf",     3'b010, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1, -1);
    run_op("divu_min_m1", 3'b001, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 65, -1);
    run_op("busy_start",  3'b001, 64'd1000, 64'd10, 64'd100, 65, 19);

    // Async reset in the middle of a divide.
    @(posedge clk); #1;
    start = 1'b1; op = 3'b001; rs1 = 64'd12345; rs2 = 64'd5;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check_eq("abort busy", 64'(busy), 64'd0);
    check_eq("abort done", 64'(done), 64'd0);
    check_eq("abort result", result, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (done) saw_done++;
    end
    check_eq("abort no_done", 64'(saw_done), 64'd0);

    run_op("divu_9_3", 3'b001, 64'd9, 64'd3, 64'd3, 65, -1);

`ifdef RV64_DIVW_EN
    run_op("divw_ovf",   3'b100, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 1, -1);
    run_op("divuw_100_7", 3'b101, 64'h0000_0001_0000_0064, 64'd7, 64'd14, 33, -1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
